// File: rtl/reg_watch_checker.sv
// reg_watch_checker: watches register write-back until a table of expected register values is met, or times out.
// Optional REG_WATCH_STRICT_EN: a mismatching RUN write to the current entry's register fails at once.
module reg_watch_checker #(
  parameter int NUM_CHECKS     = 8,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int XLEN           = 32,
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CW = $clog2(NUM_CHECKS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   num_checks,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [4:0]      cfg_reg,
  input  logic [XLEN-1:0] cfg_val,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [IW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [31:0]     cycle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] shadow_q [32];
  logic [4:0]      tbl_reg_q [NUM_CHECKS];
  logic [XLEN-1:0] tbl_val_q [NUM_CHECKS];
  logic [IW-1:0]   idx_q, idx_d, fail_idx_q, fail_idx_d;
  logic [CW-1:0]   nchk_q, nchk_d;
  logic [31:0]     cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] fail_got_q, fail_got_d, cur, cur_val;
  logic [4:0]      cur_reg;
  logic            done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic            hit, match, last, tmo, strict_bad;
  assign cur_reg = tbl_reg_q[idx_q];
  assign cur_val = tbl_val_q[idx_q];
  // A write landing this cycle is bypassed so it can satisfy the entry immediately.
  assign hit     = wb_en && wb_addr == cur_reg && wb_addr != 5'd0;
  assign cur     = hit ? wb_data : shadow_q[cur_reg];
  assign match   = cur == cur_val;
  assign last    = CW'(idx_q) + CW'(1) == nchk_q;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 32'd1;
  assign tmo     = cnt_inc >= 32'(TIMEOUT_CYCLES);
`ifdef REG_WATCH_STRICT_EN
  assign strict_bad = hit && wb_data != cur_val;
`else
  assign strict_bad = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nchk_d     = nchk_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    case (state_q)
      RUN: begin
        cnt_d = cnt_inc;
        if (match && last) begin
          state_d = PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (match) begin
          idx_d = idx_q + IW'(1);
        end else if (strict_bad || tmo) begin
          state_d    = FAIL;
          done_d     = 1'b1;
          tmo_d      = !strict_bad;
          fail_idx_d = idx_q;
          fail_got_d = cur;
        end
      end
      default: begin
        if (start) begin
          state_d    = num_checks == '0 ? PASS : RUN;
          idx_d      = '0;
          nchk_d     = num_checks;
          cnt_d      = '0;
          done_d     = num_checks == '0;
          pass_d     = num_checks == '0;
          tmo_d      = 1'b0;
          fail_idx_d = '0;
          fail_got_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      nchk_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nchk_q     <= nchk_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_reg_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
    end else begin
      if (wb_en && wb_addr != 5'd0) shadow_q[wb_addr] <= wb_data;
      if (cfg_we && state_q != RUN) begin
        tbl_reg_q[cfg_idx] <= cfg_reg;
        tbl_val_q[cfg_idx] <= cfg_val;
      end
    end
  end
  assign busy      = state_q == RUN;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign fail_idx  = fail_idx_q;
  assign fail_got  = fail_got_q;
  assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_reg_watch_checker.sv
// tb_reg_watch_checker: directed checks of reg_watch_checker at default parameters.
module tb_reg_watch_checker;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, cfg_we = 1'b0, wb_en = 1'b0;
  logic [3:0]  num_checks = '0;
  logic [2:0]  cfg_idx = '0;
  logic [4:0]  cfg_reg = '0, wb_addr = '0;
  logic [31:0] cfg_val = '0, wb_data = '0;
  logic        busy, done, pass, timeout;
  logic [2:0]  fail_idx;
  logic [31:0] fail_got, cycle_cnt;
  int total = 0, bad = 0;

  reg_watch_checker dut (
    .clk(clk), .rst(rst), .start(start), .num_checks(num_checks),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_idx(fail_idx), .fail_got(fail_got), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  task automatic cfg(input logic [2:0] i, input logic [4:0] r, input logic [31:0] v);
    cfg_we = 1'b1; cfg_idx = i; cfg_reg = r; cfg_val = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] n);
    num_checks = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    rst = 1'b1;
    // single entry, write at RUN cycle 5
    cfg(3'd0, 5'd14, 32'd14);
    go(4'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick(5);
    chk("t1_cnt5", cycle_cnt, 32'd5);
    wb(5'd14, 32'd14);
    chk("t1_pass", {30'd0, done, pass}, 32'd3);
    chk("t1_cnt", cycle_cnt, 32'd6);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    // two entries in order
    do_reset();
    cfg(3'd0, 5'd1, 32'd500);
    cfg(3'd1, 5'd2, 32'd100);
    go(4'd2);
    tick(2);
    wb(5'd1, 32'd500);
    chk("t2_mid_busy", {31'd0, busy}, 32'd1);
    wb(5'd2, 32'd100);
    chk("t2_pass", {30'd0, done, pass}, 32'd3);
    chk("t2_cnt", cycle_cnt, 32'd4);
    // reverse order: x2 later satisfied from the shadow copy
    do_reset();
    cfg(3'd0, 5'd1, 32'd500);
    cfg(3'd1, 5'd2, 32'd100);
    go(4'd2);
    wb(5'd2, 32'd100);
    tick();
    wb(5'd1, 32'd500);
    chk("t3_after_x1_busy", {31'd0, busy}, 32'd1);
    chk("t3_after_x1_done", {31'd0, done}, 32'd0);
    tick();
    chk("t3_pass", {30'd0, done, pass}, 32'd3);
    chk("t3_cnt", cycle_cnt, 32'd4);
    // timeout at RUN cycle 100
    do_reset();
    cfg(3'd0, 5'd3, 32'd77);
    go(4'd1);
    tick(99);
    chk("t4_cnt99", cycle_cnt, 32'd99);
    chk("t4_busy99", {31'd0, busy}, 32'd1);
    tick();
    chk("t4_flags", {29'd0, done, pass, timeout}, 32'd5);
    chk("t4_cnt", cycle_cnt, 32'd100);
    chk("t4_idx", {29'd0, fail_idx}, 32'd0);
    chk("t4_got", fail_got, 32'd0);
    tick(3);
    chk("t4_hold_flags", {29'd0, done, pass, timeout}, 32'd5);
    chk("t4_hold_cnt", cycle_cnt, 32'd100);
    // mismatching write to the watched register
    do_reset();
    cfg(3'd0, 5'd5, 32'd7);
    go(4'd1);
    wb(5'd5, 32'd3);
`ifdef REG_WATCH_STRICT_EN
    chk("t5_flags", {29'd0, done, pass, timeout}, 32'd4);
    chk("t5_got", fail_got, 32'd3);
    chk("t5_idx", {29'd0, fail_idx}, 32'd0);
`else
    chk("t5_still_busy", {31'd0, busy}, 32'd1);
    wb(5'd5, 32'd7);
    chk("t5_pass", {29'd0, done, pass, timeout}, 32'd6);
    chk("t5_cnt", cycle_cnt, 32'd2);
`endif
    // x0 entry and zero-length table
    do_reset();
    cfg(3'd0, 5'd0, 32'd0);
    go(4'd1);
    wb(5'd0, 32'd9);
    chk("t6_x0_pass", {30'd0, done, pass}, 32'd3);
    chk("t6_x0_cnt", cycle_cnt, 32'd1);
    go(4'd0);
    chk("t6_zero_pass", {30'd0, done, pass}, 32'd3);
    chk("t6_zero_cnt", cycle_cnt, 32'd0);
    chk("t6_zero_busy", {31'd0, busy}, 32'd0);
    // reset mid-run, then a clean run with a RUN-time table write ignored
    do_reset();
    cfg(3'd0, 5'd6, 32'd60);
    go(4'd1);
    tick(10);
    chk("t7_cnt10", cycle_cnt, 32'd10);
    rst = 1'b0;
    #1;
    chk("t7_abort", {30'd0, busy, done}, 32'd0);
    chk("t7_abort_cnt", cycle_cnt, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("t7_idle", {30'd0, busy, done}, 32'd0);
    cfg(3'd0, 5'd6, 32'd60);
    go(4'd1);
    cfg(3'd0, 5'd6, 32'd61);
    wb(5'd6, 32'd60);
    chk("t7_pass", {30'd0, done, pass}, 32'd3);
    chk("t7_cnt", cycle_cnt, 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
